// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port synchronous memory (active-low WE, 1-cycle registered read).
// Latency: grant and memory command are combinational; read data returns with rvalidX one cycle after the accept.
// Backpressure: a requester holds its request until gntX; an owner under lock blocks the other for at most LOCK_MAX accesses.
// Build option MEM_ARB_FIXED_PRIO_EN: requester 0 always wins simultaneous IDLE requests (no round-robin pointer).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 2,
    parameter int WORD_WIDTH = 8,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  lock0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] adrs0,
    input  logic [WORD_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [WORD_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  lock1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] adrs1,
    input  logic [WORD_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [WORD_WIDTH-1:0] rdata1,
    output logic                  mem_we_n,
    output logic [ADDR_WIDTH-1:0] mem_adrs,
    output logic [WORD_WIDTH-1:0] mem_d_in,
    input  logic [WORD_WIDTH-1:0] mem_q
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic rr_ptr;
`endif

    // State and lock counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Grant selection and ownership transitions; nothing is granted while reset is held
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                        gnt0 = 1'b1;
`else
                        gnt0 = ~rr_ptr;
                        gnt1 = rr_ptr;
`endif
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                    // A lock ceiling of one means a lock can never extend ownership
                    if (LOCK_MAX > 1) begin
                        if (gnt0 && lock0) begin
                            state_nxt    = OWN0;
                            lock_cnt_nxt = CNT_ONE;
                        end else if (gnt1 && lock1) begin
                            state_nxt    = OWN1;
                            lock_cnt_nxt = CNT_ONE;
                        end
                    end
                end
                OWN0: begin
                    gnt0 = req0;
                    if (req0) begin
                        if (!lock0 || lock_cnt == CNT_LAST) begin
                            state_nxt    = IDLE;
                            lock_cnt_nxt = '0;
                        end else begin
                            lock_cnt_nxt = lock_cnt + CNT_ONE;
                        end
                    end else if (!lock0) begin
                        state_nxt    = IDLE;
                        lock_cnt_nxt = '0;
                    end
                end
                OWN1: begin
                    gnt1 = req1;
                    if (req1) begin
                        if (!lock1 || lock_cnt == CNT_LAST) begin
                            state_nxt    = IDLE;
                            lock_cnt_nxt = '0;
                        end else begin
                            lock_cnt_nxt = lock_cnt + CNT_ONE;
                        end
                    end else if (!lock1) begin
                        state_nxt    = IDLE;
                        lock_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                end
            endcase
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    // Round-robin pointer favours the requester that did not win the last accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (gnt0) begin
            rr_ptr <= 1'b1;
        end else if (gnt1) begin
            rr_ptr <= 1'b0;
        end
    end
`endif

    // Memory command follows the granted requester; idle bus is a benign read of address 0
    always_comb begin
        mem_we_n = 1'b1;
        mem_adrs = '0;
        mem_d_in = '0;
        if (gnt0) begin
            mem_we_n = ~we0;
            mem_adrs = adrs0;
            mem_d_in = wdata0;
        end else if (gnt1) begin
            mem_we_n = ~we1;
            mem_adrs = adrs1;
            mem_d_in = wdata1;
        end
    end

    // Read-return tags: one-cycle pulse marking whose read the memory is returning
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

    assign rdata0 = rvalid0 ? mem_q : '0;
    assign rdata1 = rvalid1 ? mem_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a behavioural model with its own memory image.
// Latency: model predicts grants per cycle and read returns one cycle after accept.
// Backpressure: requesters hold their inputs until granted, as the client FSMs do.
module tb_mem_arbiter;

    localparam int AW = 2;
    localparam int WW = 8;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 0, lock0 = 0, we0 = 0, req1 = 0, lock1 = 0, we1 = 0;
    logic [AW-1:0] adrs0 = '0, adrs1 = '0;
    logic [WW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we_n;
    logic [WW-1:0] rdata0, rdata1, mem_d_in;
    logic [AW-1:0] mem_adrs;
    logic [WW-1:0] mem_q = '0;

    mem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .lock0(lock0), .we0(we0), .adrs0(adrs0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .lock1(lock1), .we1(we1), .adrs1(adrs1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_we_n(mem_we_n), .mem_adrs(mem_adrs), .mem_d_in(mem_d_in), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Stand-in for the memory block: active-low write, registered read of old contents
    logic [WW-1:0] mem_arr [4] = '{default: '0};
    always @(posedge clk) begin
        if (!mem_we_n) mem_arr[mem_adrs] <= mem_d_in;
        mem_q <= mem_arr[mem_adrs];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural reference: who holds the memory, how long, and who is favoured next
    int            owner  = -1;
    int            burst  = 0;
    int            favour = 0;
    logic [WW-1:0] ref_mem [4] = '{default: '0};
    logic          exp_rv0 = 0, exp_rv1 = 0;
    logic [WW-1:0] exp_rd0 = '0, exp_rd1 = '0;
    int            obs_g = 2;
    logic          obs_we_n = 1;
    logic [WW-1:0] obs_rd0 = '0;

    task automatic model_reset();
        owner = -1; burst = 0; favour = 0;
        exp_rv0 = 0; exp_rv1 = 0;
    endtask

    // One clock cycle: predict, compare at negedge, advance the model across the posedge
    task automatic step();
        int g;
        logic w;
        logic [AW-1:0] a;
        logic [WW-1:0] d;
        logic lk, rq;
        logic nrv0, nrv1;
        logic [WW-1:0] nrd0, nrd1;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            if (owner == 0) g = req0 ? 0 : -1;
            else if (owner == 1) g = req1 ? 1 : -1;
            else if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                g = 0;
`else
                g = favour;
`endif
            end else if (req0) g = 0;
            else if (req1) g = 1;
        end
        w  = (g == 0) ? we0 : (g == 1) ? we1 : 1'b0;
        a  = (g == 0) ? adrs0 : (g == 1) ? adrs1 : '0;
        d  = (g == 0) ? wdata0 : (g == 1) ? wdata1 : '0;
        lk = (g == 0) ? lock0 : lock1;

        obs_g    = (gnt0 && gnt1) ? 3 : gnt0 ? 0 : gnt1 ? 1 : 2;
        obs_we_n = mem_we_n;
        obs_rd0  = rdata0;
        chk("gnt0", 32'(gnt0), 32'(g == 0));
        chk("gnt1", 32'(gnt1), 32'(g == 1));
        chk("mem_we_n", 32'(mem_we_n), 32'(!(g >= 0 && w)));
        chk("mem_adrs", 32'(mem_adrs), 32'(a));
        chk("mem_d_in", 32'(mem_d_in), 32'(d));
        chk("rvalid0", 32'(rvalid0), 32'(exp_rv0));
        chk("rvalid1", 32'(rvalid1), 32'(exp_rv1));
        chk("rdata0", 32'(rdata0), exp_rv0 ? 32'(exp_rd0) : 32'd0);
        chk("rdata1", 32'(rdata1), exp_rv1 ? 32'(exp_rd1) : 32'd0);

        nrv0 = (g == 0) && !w;
        nrv1 = (g == 1) && !w;
        nrd0 = ref_mem[a];
        nrd1 = ref_mem[a];
        if (g >= 0 && w) ref_mem[a] = d;
        if (g >= 0) begin
            favour = 1 - g;
            if (owner < 0) begin
                if (lk && LM > 1) begin owner = g; burst = 1; end
            end else begin
                burst++;
                if (!lk || burst >= LM) begin owner = -1; burst = 0; end
            end
        end else if (owner >= 0) begin
            rq = (owner == 0) ? req0 : req1;
            lk = (owner == 0) ? lock0 : lock1;
            if (!rq && !lk) begin owner = -1; burst = 0; end
        end
        @(posedge clk);
        if (rst) model_reset();
        else begin
            exp_rv0 = nrv0; exp_rv1 = nrv1; exp_rd0 = nrd0; exp_rd1 = nrd1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        step();
        step();
        rst = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t required below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [6];
        int obs_seq [6];
        // Reset then idle
        do_reset();
        for (int i = 0; i < 5; i++) step();

        // Write then read from requester 0
        req0 = 1; we0 = 1; adrs0 = 2; wdata0 = 8'hA5;
        step();
        chk("wr_gnt", 32'(obs_g), 32'd0);
        chk("wr_we_n", 32'(obs_we_n), 32'd0);
        we0 = 0;
        step();
        chk("rd_gnt", 32'(obs_g), 32'd0);
        chk("rd_we_n", 32'(obs_we_n), 32'd1);
        req0 = 0;
        step();
        chk("rd_data", 32'(obs_rd0), 32'hA5);

        // Contention without lock
        do_reset();
`ifdef MEM_ARB_FIXED_PRIO_EN
        seq = '{0, 0, 0, 0, 0, 0};
`else
        seq = '{0, 1, 0, 1, 0, 0};
`endif
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; adrs0 = 2; adrs1 = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            obs_seq[i] = obs_g;
            chk("rr_gnt", 32'(obs_seq[i]), 32'(seq[i]));
        end
        req0 = 0; req1 = 0;
        step();

        // Lock ceiling: requester 0 locked for six cycles, requester 1 always pending
        do_reset();
`ifdef MEM_ARB_FIXED_PRIO_EN
        seq = '{0, 0, 0, 0, 0, 0};
`else
        seq = '{0, 0, 0, 0, 1, 0};
`endif
        req0 = 1; lock0 = 1; req1 = 1; lock1 = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            obs_seq[i] = obs_g;
            chk("ceiling_gnt", 32'(obs_seq[i]), 32'(seq[i]));
        end
        req0 = 0; lock0 = 0; req1 = 0;
        step();

        // Lock release: two locked accesses then requester 0 goes away
        do_reset();
        req0 = 1; lock0 = 1; req1 = 1;
        step();
        chk("rel_gnt_a", 32'(obs_g), 32'd0);
        lock0 = 0;
        step();
        chk("rel_gnt_b", 32'(obs_g), 32'd0);
        req0 = 0;
        step();
        chk("rel_gnt_c", 32'(obs_g), 32'd1);
        req1 = 0;
        step();

        // Asynchronous reset between a read accept and its return
        do_reset();
        req0 = 1; lock0 = 1; we0 = 0; adrs0 = 1;
        step();
        rst = 1;
        #1;
        chk("rst_rvalid0", 32'(rvalid0), 32'd0);
        model_reset();
        req0 = 0; lock0 = 0;
        step();
        rst = 0;
        req1 = 1; we1 = 0; adrs1 = 3;
        step();
        chk("post_rst_gnt1", 32'(obs_g), 32'd1);
        req1 = 0;
        step();

        // Random traffic; each requester holds its inputs until granted
        for (int c = 0; c < 600; c++) begin
            if (!req0 || obs_g == 0) begin
                req0 = ($urandom_range(0, 99) < 60);
                lock0 = ($urandom_range(0, 99) < 40);
                we0 = ($urandom_range(0, 99) < 35);
                adrs0 = AW'($urandom);
                wdata0 = WW'($urandom);
            end
            if (!req1 || obs_g == 1) begin
                req1 = ($urandom_range(0, 99) < 60);
                lock1 = ($urandom_range(0, 99) < 40);
                we1 = ($urandom_range(0, 99) < 35);
                adrs1 = AW'($urandom);
                wdata1 = WW'($urandom);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port synchronous memory block (`memory_logic`). That memory has an active-low write enable and a one-cycle registered read.
- Grants one access per cycle, round-robin by default, with an optional bounded lock for back-to-back bursts.
- Drives the memory command pins and routes returned read data to the requester that issued the read.
- Sits between the two client FSMs and the memory instance.

Parameters:
- ADDR_WIDTH, 2, memory address width.
- WORD_WIDTH, 8, memory data width.
- LOCK_MAX, 4, max consecutive accesses one requester may hold under lock (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req0  in  1  requester 0 access request
- lock0  in  1  requester 0 wants to keep ownership after this access
- we0  in  1  requester 0: 1 = write, 0 = read
- adrs0  in  ADDR_WIDTH  requester 0 address
- wdata0  in  WORD_WIDTH  requester 0 write data
- gnt0  out  1  requester 0 access accepted this cycle
- rvalid0  out  1  requester 0 read data valid
- rdata0  out  WORD_WIDTH  requester 0 read data
- req1, lock1, we1, adrs1, wdata1, gnt1, rvalid1, rdata1: same as above, for requester 1
- mem_we_n  out  1  memory write enable, active-low
- mem_adrs  out  ADDR_WIDTH  memory address
- mem_d_in  out  WORD_WIDTH  memory write data
- mem_q  in  WORD_WIDTH  memory read data, valid the cycle after the read edge

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset values:
  - state=IDLE, rr_ptr=0, lock_cnt=0.
  - gnt0/1=0, rvalid0/1=0, rdata0/1=0.
  - mem_we_n=1, mem_adrs=0, mem_d_in=0.
- Handshake:
  - Requester holds req/we/adrs/wdata stable until it sees gntX=1.
  - An access is accepted at the posedge where reqX&gntX=1.
  - gntX is combinational from the current state and req inputs. At most one gnt is high per cycle.
- Memory command:
  - mem_adrs/mem_d_in/mem_we_n are combinational from the granted requester.
  - mem_we_n = ~weX when granted.
  - With no grant: mem_we_n=1, mem_adrs=0, mem_d_in=0. No spurious write is allowed.
- Read return:
  - rvalidX is registered; it goes high the cycle after an accepted read by X, for exactly 1 cycle.
  - rdataX = mem_q while rvalidX=1, otherwise 0.
  - Writes produce no rvalid.
  - Throughput is 1 access/cycle. Back-to-back reads give back-to-back rvalid.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant rr_ptr.
  - On accept with lockX=1 and LOCK_MAX>1: go to OWNX with lock_cnt=1.
  - Otherwise remain IDLE.
- OWNX:
  - Only X may be granted; the other requester waits even if X is idle.
  - On accept: lock_cnt++.
  - Exit to IDLE when:
    - an accept occurs with lockX=0, or
    - reqX=0 and lockX=0, or
    - lock_cnt reaches LOCK_MAX on an accept (forced release).
- rr_ptr:
  - On every accept by X, rr_ptr <= ~X.
  - A single requester alone is granted every cycle.
- Lock ceiling:
  - After a forced release, the other requester, if requesting, wins the next IDLE arbitration (guaranteed by rr_ptr).
- Reset mid-operation:
  - A pending rvalid is dropped and ownership is cleared.
  - A write accepted at the same edge as reset assertion is not guaranteed.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins simultaneous requests in IDLE; rr_ptr is not implemented; lock behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then all req=0 for 5 cycles.
  - Required: mem_we_n=1 throughout; all gnt/rvalid=0; mem_adrs=0.
- Write then read, single requester:
  - req0 write adrs=2 data=8'hA5, then req0 read adrs=2.
  - Required: gnt0 on each; mem_we_n=0 only in the write cycle; rvalid0=1 one cycle after the read accept with rdata0=8'hA5; rvalid1 stays 0.
- Contention, round-robin:
  - req0 and req1 both reading, held for 4 cycles, no lock.
  - Required: grants alternate 0,1,0,1; each rvalid follows its grant by 1 cycle.
  - With MEM_ARB_FIXED_PRIO_EN defined: gnt0 on all 4 cycles.
- Lock ceiling:
  - LOCK_MAX=4; req0 with lock0=1 held for 6 cycles; req1 held high throughout.
  - Required: gnt0 for 4 consecutive cycles, then gnt1, then gnt0.
- Lock release:
  - req0 locks for 2 accesses, then drops lock0 with req0=0; req1 is pending.
  - Required: gnt1 in the first cycle after release; no cycle has both gnt.
- Reset mid-read:
  - Assert rst asynchronously between a read accept and its return edge.
  - Required: rvalid0=0 immediately and stays 0; state returns to IDLE.
